cpu6_shft_mc: RTL

Multi-cycle iterative shift unit for the cpu6 execute stage, an alternative to the single-cycle combinational shifter. It takes the execute-stage operand and shift amount, implements SLL/SRL/SRA (SLLI/SRLI/SRAI share the same path), and returns the result to the execute-stage result mux. While it works, it raises a stall request to the hazard unit. Each cycle it applies one step of 16, 4 or 1 bit positions, the same decomposition as the existing shift16/shift4/shift1 network, which shortens the execute critical path.

---
 rtl/cpu6_shft_mc.sv | 103 ++++++++++
 1 files changed

// File: rtl/cpu6_shft_mc.sv
// cpu6 execute-stage iterative shifter: SLL/SRL/SRA in steps of 16/4/1.
// Raises a stall while stepping and pulses done with the result.
module cpu6_shft_mc #(
    parameter int XLEN = 32,
    localparam int AW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            shft_start,
    input  logic            shft_flush,
    input  logic [XLEN-1:0] shft_src,
    input  logic [AW-1:0]   shft_amt,
    input  logic            shft_lr,
    input  logic            shft_arith,
    output logic            shft_busy,
    output logic            shft_done,
    output logic [XLEN-1:0] shft_out
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] work;
    logic [XLEN-1:0] work_step;
    logic [AW-1:0]   rem;
    logic [AW-1:0]   rem_step;
    logic            lr;
    logic            sgn;
    logic            accept;

    assign accept = shft_start & (state == IDLE || state == DONE) & ~shft_flush;

    // One step per cycle, largest stride that still fits in rem.
    always_comb begin
        work_step = work;
        rem_step  = rem;
        if (rem >= AW'(16)) begin
            rem_step  = rem - AW'(16);
            work_step = lr ? {{16{sgn}}, work[XLEN-1:16]}
                           : {work[XLEN-17:0], 16'b0};
        end else if (rem >= AW'(4)) begin
            rem_step  = rem - AW'(4);
            work_step = lr ? {{4{sgn}}, work[XLEN-1:4]}
                           : {work[XLEN-5:0], 4'b0};
        end else begin
            rem_step  = rem - AW'(1);
            work_step = lr ? {sgn, work[XLEN-1:1]}
                           : {work[XLEN-2:0], 1'b0};
        end
    end

    always_comb begin
        state_nxt = state;
        if (shft_flush) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (shft_start)
                        state_nxt = (shft_amt == '0) ? DONE : RUN;
                    else
                        state_nxt = IDLE;
                end
                RUN: begin
                    if (rem_step == '0)
                        state_nxt = DONE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            work  <= '0;
            rem   <= '0;
            lr    <= 1'b0;
            sgn   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                work <= shft_src;
                rem  <= shft_amt;
                lr   <= shft_lr;
                sgn  <= shft_src[XLEN-1] & shft_lr & shft_arith;
            end else if (state == RUN && !shft_flush) begin
                work <= work_step;
                rem  <= rem_step;
            end
        end
    end

    assign shft_busy = accept | (state == RUN && !shft_flush);
    assign shft_done = (state == DONE);
    assign shft_out  = work;

endmodule
